// File: rtl/borrow_decrement_subtractor_pkg.sv
// Shared constants for the borrow-decrement subtractor: widths, flag-bus bit positions
// (common with the carry-increment adder) and the single-bit full-subtract cell.
package borrow_decrement_subtractor_pkg;

    localparam int unsigned BDS_WIDTH = 32;
    localparam int unsigned BDS_HALF  = BDS_WIDTH / 2;

    typedef enum int unsigned {
        FLAG_BOUT = 0,
        FLAG_OVF  = 1,
        FLAG_ZERO = 2
    } flag_idx_e;

    localparam int unsigned FLAG_W = 3;

    // Returns {borrow_out, difference} of x - y - bi.
    function automatic logic [1:0] fsub(input logic x, input logic y, input logic bi);
        return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor used in the upper-half decrement chain.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/borrow_decrement_subtractor.sv
// Two-stage pipelined subtractor: diff = a - b - bin with borrow, overflow and zero flags.
// Upper half is subtracted with zero borrow in S1 and decremented by the lower borrow in S2.
module borrow_decrement_subtractor
    import borrow_decrement_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = BDS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned HALF = WIDTH / 2;

    // Stage-1 ripple-borrow subtracts
    logic [HALF:0]   lo_bw;
    logic [HALF:0]   hi_bw;
    logic [HALF-1:0] lo_sub;
    logic [HALF-1:0] hi_sub;

    assign lo_bw[0] = bin;
    assign hi_bw[0] = 1'b0;

    for (genvar i = 0; i < HALF; i++) begin : g_ripple
        assign {lo_bw[i+1], lo_sub[i]} = fsub(a[i], b[i], lo_bw[i]);
        assign {hi_bw[i+1], hi_sub[i]} = fsub(a[HALF+i], b[HALF+i], hi_bw[i]);
    end

    logic            s1_valid_q;
    logic [HALF-1:0] lo_diff_q;
    logic [HALF-1:0] hi_raw_q;
    logic            b0_q;
    logic            b1_q;
    logic            a_msb_q;
    logic            b_msb_q;

    logic out_valid_q;
    logic s2_adv;
    logic in_xfer;

    assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            lo_diff_q  <= '0;
            hi_raw_q   <= '0;
            b0_q       <= 1'b0;
            b1_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_xfer) begin
                lo_diff_q <= lo_sub;
                hi_raw_q  <= hi_sub;
                b0_q      <= lo_bw[HALF];
                b1_q      <= hi_bw[HALF];
                a_msb_q   <= a[WIDTH-1];
                b_msb_q   <= b[WIDTH-1];
            end
        end
    end

    // Stage-2 decrement of the upper half by the lower-half borrow
    logic [HALF:0]   dec_bw;
    logic [HALF-1:0] hi_dec;

    assign dec_bw[0] = b0_q;

    for (genvar i = 0; i < HALF; i++) begin : g_dec
        half_subtractor u_hs (
            .x  (hi_raw_q[i]),
            .y  (dec_bw[i]),
            .d  (hi_dec[i]),
            .bo (dec_bw[i+1])
        );
    end

    logic [WIDTH-1:0]  diff_d;
    logic [WIDTH-1:0]  diff_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;

    always_comb begin
        diff_d             = {hi_dec, lo_diff_q};
        flags_d            = '0;
        flags_d[FLAG_BOUT] = b1_q | dec_bw[HALF];
        flags_d[FLAG_OVF]  = (a_msb_q ^ b_msb_q) & (diff_d[WIDTH-1] ^ a_msb_q);
        flags_d[FLAG_ZERO] = ~|diff_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            flags_q     <= '0;
        end else if (s2_adv) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
            flags_q     <= flags_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = flags_q[FLAG_BOUT];
    assign ovf       = flags_q[FLAG_OVF];
    assign zero      = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_borrow_decrement_subtractor.sv
// Scoreboard bench: accepted operands push an expected result, a negedge monitor pops and
// compares each accepted output, checks stall stability and (in directed phases) latency.
module tb_borrow_decrement_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    borrow_decrement_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t ovr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    bit chk_lat   = 1'b0;
    bit saw_block = 1'b0;
    bit held_v    = 1'b0;
    logic [34:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic for the unsigned result, signed range test for overflow.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        exp_t e;
        logic [32:0] u;
        longint r;
        u = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        r = longint'($signed(x)) - longint'($signed(y)) - longint'({63'd0, bi});
        e.diff = u[31:0];
        e.bout = u[32];
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (u[31:0] == 32'd0);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.diff = d; e.bout = bo; e.ovf = ov; e.zero = z; e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (held_v)
                    check("stall_hold", 64'({diff, bout, ovf, zero}), 64'(held));
                if (out_ready) begin
                    held_v = 1'b0;
                    if (sbq.size() == 0) begin
                        check("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        e = sbq.pop_front();
                        n_out++;
                        check("result", 64'({diff, bout, ovf, zero}),
                              64'({e.diff, e.bout, e.ovf, e.zero}));
                        if (chk_lat)
                            check("latency", 64'(cyc - e.cyc), 64'(2));
                    end
                end else begin
                    held_v = 1'b1;
                    held   = {diff, bout, ovf, zero};
                end
            end else if (held_v) begin
                check("stall_dropped", 64'(0), 64'(1));
                held_v = 1'b0;
            end
            if (!in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) begin
                e = (ovr_q.size() != 0) ? ovr_q.pop_front() : model(a, b, bin);
                e.cyc = cyc;
                sbq.push_back(e);
                n_in++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic bi,
                        input bit use_ovr, input exp_t e);
        bit got;
        if (use_ovr) ovr_q.push_back(e);
        a = aa; b = bb; bin = bi; in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!got) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #2;
            done = (sbq.size() == 0) && !out_valid;
        end
        check("drain", 64'(done), 64'(1));
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0001_0000;
            5: return {16'($urandom), 16'h0000};
            default: return $urandom;
        endcase
    endfunction

    exp_t none;
    int   n0;

    initial begin
        none      = mk(32'd0, 1'b0, 1'b0, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 32'h1111_1111; b = 32'h2222_2222; bin = 1'b1;

        // Reset held for two cycles with in_valid asserted
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_outputs", 64'({diff, bout, ovf, zero}), 64'(0));
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_idle", 64'(out_valid), 64'(0));
        step();

        // Directed values with exact latency
        chk_lat = 1'b1;
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
        send(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h0000_FFFF, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
        send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
        drain();
        chk_lat = 1'b0;

        // Back-pressure: 8 operand sets, out_ready low for cycles 3..6
        n0 = n_out;
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom), 1'b0, none);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", 64'(saw_block), 64'(1));
        check("bp_count", 64'(n_out - n0), 64'(8));

        // Mid-stream reset with two results in flight
        out_ready = 1'b0;
        send(32'hAAAA_0000, 32'h0000_0001, 1'b0, 1'b0, none);
        send(32'h5555_5555, 32'h1111_1111, 1'b1, 1'b0, none);
        check("inflight_count", 64'(sbq.size()), 64'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        step();
        n0 = n_out;
        chk_lat = 1'b1;
        send(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1, 1'b1, mk(32'hDEAC_FFFF, 1'b0, 1'b0, 1'b0));
        drain();
        chk_lat = 1'b0;
        check("mid_rst_new_result", 64'(n_out - n0), 64'(1));

        // Random traffic with random valid/ready
        n0 = n_in;
        for (int c = 0; c < 60000 && (n_in - n0) < 10000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = rnd();
            b         = rnd();
            bin       = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("random_accepted", 64'((n_in - n0) >= 10000), 64'(1));
        drain();
        check("total_in_out", 64'(n_out), 64'(n_in - 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
